// File: rtl/vector_data_mem_responder.sv
// Byte-addressed data-memory responder: scalar accesses complete at accept, vector accesses
// move LANES elements per beat. Optional bounds checking via `define DMEM_BOUNDS_CHECK_EN.
module vector_data_mem_responder #(
  parameter int unsigned L     = 8,
  parameter int unsigned I     = 20,
  parameter int unsigned A     = 32,
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned LANES = 4
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           req_valid_i,
  output logic           req_ready_o,
  input  logic           op_vec_i,
  input  logic           we_i,
  input  logic [A-1:0]   addr_i,
  input  logic [I*L-1:0] vec_wdata_i,
  input  logic [L-1:0]   sca_wdata_i,
  output logic [I*L-1:0] vec_rdata_o,
  output logic [L-1:0]   sca_rdata_o,
  output logic           done_o,
  output logic           err_o
);

  localparam int unsigned NB = (I + LANES - 1) / LANES;
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned BW = (NB > 1) ? $clog2(NB) : 1;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t         r_state;
  state_t         w_state_nx;
  logic [BW-1:0]  r_beat;
  logic           r_we;
  logic [A-1:0]   r_addr;
  logic [I*L-1:0] r_wdata;
  logic [L-1:0]   r_mem [DEPTH];
  logic [I*L-1:0] r_vrdata;
  logic [L-1:0]   r_srdata;

  logic           w_accept;
  logic           w_oob;
  logic           w_last;
  logic [AW-1:0]  w_sidx;
  int unsigned    w_k       [LANES];
  logic           w_lane_en [LANES];
  logic [AW-1:0]  w_eaddr   [LANES];

  // Element address (base + k) mod DEPTH, computed one bit wider so the carry is kept.
  function automatic logic [AW-1:0] f_idx(input logic [A-1:0] base, input int unsigned k);
    logic [A:0] s;
    s = {1'b0, base} + (A+1)'(k);
    return AW'(s % (A+1)'(DEPTH));
  endfunction

  assign w_accept = req_valid_i && (r_state == S_IDLE);
  assign w_last   = (r_beat == BW'(NB - 1));
  assign w_sidx   = f_idx(addr_i, 0);

`ifdef DMEM_BOUNDS_CHECK_EN
  logic [A:0] w_end;
  logic       r_err;

  assign w_end = {1'b0, addr_i} + (A+1)'(op_vec_i ? I : 1);
  assign w_oob = (w_end > (A+1)'(DEPTH));
  assign err_o = r_err && (r_state == S_DONE);

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_err <= 1'b0;
    end else if (w_accept) begin
      r_err <= w_oob;
    end
  end
`else
  assign w_oob = 1'b0;
  assign err_o = 1'b0;
`endif

  always_comb begin
    w_state_nx  = r_state;
    req_ready_o = 1'b0;
    done_o      = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready_o = 1'b1;
        if (w_accept) w_state_nx = (op_vec_i && !w_oob) ? S_BUSY : S_DONE;
      end
      S_BUSY: if (w_last) w_state_nx = S_DONE;
      S_DONE: begin
        done_o     = 1'b1;
        w_state_nx = S_IDLE;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_beat  <= '0;
    end else begin
      r_state <= w_state_nx;
      if (w_accept) r_beat <= '0;
      else if (r_state == S_BUSY) r_beat <= r_beat + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (w_accept) begin
      r_we    <= we_i;
      r_addr  <= addr_i;
      r_wdata <= vec_wdata_i;
    end
  end

  // Per-lane element index for the current beat; lanes past the last element are masked.
  always_comb begin
    for (int unsigned j = 0; j < LANES; j++) begin
      w_k[j]       = 32'(r_beat) * LANES + j;
      w_lane_en[j] = (r_state == S_BUSY) && (w_k[j] < I);
      w_eaddr[j]   = f_idx(r_addr, w_k[j]);
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      if (w_accept && !op_vec_i && we_i && !w_oob) r_mem[w_sidx] <= sca_wdata_i;
      for (int unsigned j = 0; j < LANES; j++) begin
        if (w_lane_en[j] && r_we) r_mem[w_eaddr[j]] <= r_wdata[w_k[j]*L +: L];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_vrdata <= '0;
      r_srdata <= '0;
    end else begin
      if (w_accept && !op_vec_i && !we_i && !w_oob) r_srdata <= r_mem[w_sidx];
      for (int unsigned j = 0; j < LANES; j++) begin
        if (w_lane_en[j] && !r_we) r_vrdata[w_k[j]*L +: L] <= r_mem[w_eaddr[j]];
      end
    end
  end

  assign vec_rdata_o = r_vrdata;
  assign sca_rdata_o = r_srdata;

endmodule

// File: tb/tb_vector_data_mem_responder.sv
// Scoreboard bench for vector_data_mem_responder (default build, bounds checking off).
module tb_vector_data_mem_responder;

  localparam int L = 8;
  localparam int I = 20;
  localparam int A = 32;
  localparam int DEPTH = 1024;
  localparam int LANES = 4;

  logic           CLK = 1'b0;
  logic           RST = 1'b1;
  logic           req_valid_i = 1'b0;
  logic           req_ready_o;
  logic           op_vec_i = 1'b0;
  logic           we_i = 1'b0;
  logic [A-1:0]   addr_i = '0;
  logic [I*L-1:0] vec_wdata_i = '0;
  logic [L-1:0]   sca_wdata_i = '0;
  logic [I*L-1:0] vec_rdata_o;
  logic [L-1:0]   sca_rdata_o;
  logic           done_o;
  logic           err_o;

  vector_data_mem_responder #(
    .L(L), .I(I), .A(A), .DEPTH(DEPTH), .LANES(LANES)
  ) dut (
    .CLK(CLK), .RST(RST),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .op_vec_i(op_vec_i), .we_i(we_i), .addr_i(addr_i),
    .vec_wdata_i(vec_wdata_i), .sca_wdata_i(sca_wdata_i),
    .vec_rdata_o(vec_rdata_o), .sca_rdata_o(sca_rdata_o),
    .done_o(done_o), .err_o(err_o)
  );

  always #5 CLK = ~CLK;

  int unsigned cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;

  typedef struct {
    int unsigned    due;
    logic [7:0]     sca;
    logic [I*L-1:0] vec;
    logic           err;
  } exp_t;

  exp_t q[$];
  logic [7:0]     sh_sca;
  logic [I*L-1:0] sh_vec;

  task automatic check(input string nm, input logic [I*L-1:0] act, input logic [I*L-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  always @(negedge CLK) begin
    if (done_o === 1'b1) begin
      check("done_expected", (q.size() != 0), 1);
      if (q.size() != 0) begin
        check("done_latency", cyc, q[0].due);
        check("sca_rdata", sca_rdata_o, q[0].sca);
        check("vec_rdata", vec_rdata_o, q[0].vec);
        check("err", err_o, q[0].err);
        void'(q.pop_front());
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic do_req(input logic vec, input logic we, input int unsigned addr,
                        input logic [I*L-1:0] vw, input logic [7:0] sw,
                        input logic exp_done, input logic hold);
    op_vec_i = vec; we_i = we; addr_i = addr;
    vec_wdata_i = vw; sca_wdata_i = sw; req_valid_i = 1'b1;
    for (int t = 0; t < 50 && !req_ready_o; t++) begin
      @(posedge CLK); #1;
    end
    check("ready_before_accept", req_ready_o, 1);
    if (exp_done) q.push_back('{cyc + (vec ? 32'd6 : 32'd1), sh_sca, sh_vec, 1'b0});
    @(posedge CLK); #1;
    if (!hold) req_valid_i = 1'b0;
  endtask

  logic [I*L-1:0] v100, v0, e0, v200, e200, vff, v300;
  int lowcnt;

  initial begin
    for (int k = 0; k < I; k++) begin
      v100[k*8 +: 8] = 8'(k + 1);
      v0[k*8 +: 8]   = 8'(8'hC0 + k);
      e0[k*8 +: 8]   = (k < 10) ? 8'(k + 11) : 8'(8'hC0 + k);
      v200[k*8 +: 8] = 8'(8'h50 + k);
      e200[k*8 +: 8] = (k < 12) ? 8'hFF : 8'(8'h50 + k);
      vff[k*8 +: 8]  = 8'hFF;
      v300[k*8 +: 8] = 8'(k * 7 + 3);
    end
    sh_sca = '0;
    sh_vec = '0;

    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    check("rst_ready", req_ready_o, 1);
    check("rst_done", done_o, 0);
    check("rst_vec_rdata", vec_rdata_o, 0);
    check("rst_sca_rdata", sca_rdata_o, 0);
    check("rst_err", err_o, 0);

    // Scalar write/read
    do_req(0, 1, 7, '0, 8'hA5, 1, 0);
    do_req(0, 1, 9, '0, 8'h3C, 1, 0);
    sh_sca = 8'hA5;
    do_req(0, 0, 7, '0, 8'h00, 1, 0);

    // Vector write/read, then a held request with changing address during BUSY
    do_req(1, 1, 100, v100, 8'h00, 1, 0);
    sh_vec = v100;
    do_req(1, 0, 100, '0, 8'h00, 1, 1);
    lowcnt = 0;
    while (!req_ready_o && lowcnt < 20) begin
      lowcnt++;
      addr_i = 32'(600 + lowcnt); op_vec_i = 1'b0; we_i = 1'b0;
      @(posedge CLK); #1;
    end
    check("busy_ready_low_cycles", lowcnt, 6);
    sh_sca = 8'h3C;
    do_req(0, 0, 9, '0, 8'h00, 1, 0);

    // Address wrap past DEPTH-1
    do_req(1, 1, 0, v0, 8'h00, 1, 0);
    do_req(1, 1, 1014, v100, 8'h00, 1, 0);
    sh_vec = e0;
    do_req(1, 0, 0, '0, 8'h00, 1, 0);
    sh_vec = v100;
    do_req(1, 0, 1014, '0, 8'h00, 1, 0);
    sh_sca = 8'd10;
    do_req(0, 0, 1023, '0, 8'h00, 1, 0);

    // Reset after three beats of a vector write
    do_req(1, 1, 200, v200, 8'h00, 1, 0);
    do_req(1, 1, 200, vff, 8'h00, 0, 0);
    repeat (3) @(posedge CLK);
    #1 RST = 1'b1;
    @(posedge CLK);
    #1 RST = 1'b0;
    check("abort_ready", req_ready_o, 1);
    check("abort_done", done_o, 0);
    check("abort_vec_rdata", vec_rdata_o, 0);
    check("abort_sca_rdata", sca_rdata_o, 0);
    sh_sca = '0;
    sh_vec = e200;
    do_req(1, 0, 200, '0, 8'h00, 1, 0);

    // Back-to-back vector write then read
    do_req(1, 1, 300, v300, 8'h00, 1, 0);
    sh_vec = v300;
    do_req(1, 0, 300, '0, 8'h00, 1, 0);

    for (int t = 0; t < 100 && q.size() != 0; t++) @(posedge CLK);
    #1 check("queue_drained", q.size(), 0);
    repeat (3) @(posedge CLK);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
